// File: rtl/aoi21_seq_pkg.sv
// Shared types and constant tables for the AOI21 toggle sequencer.
//   state_e   : sequencer FSM states
//   GRAY_VEC  : {IN3,IN2,IN1} driven at each VEC_IDX 0..7 (3-bit Gray order)
//   IDEAL_QN  : ideal AOI21 output for each VEC_IDX, bit i <-> index i
package aoi21_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    DONE_S = 2'd3
  } state_e;

  localparam int unsigned VEC_N = 8;

  // Index 0 is the rightmost element.
  localparam logic [VEC_N-1:0][2:0] GRAY_VEC = {
    3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000
  };

  // QN = ~(IN3 | (IN1 & IN2)) for each GRAY_VEC entry: 1,1,0,1,0,0,0,0.
  localparam logic [VEC_N-1:0] IDEAL_QN = 8'b0000_1011;

endpackage

// File: rtl/aoi21_toggle_sequencer_if.sv
// Controller/cell-bank bundle for the AOI21 toggle sequencer.
//   master : test controller and cell bank side (drives START/config and QN_OBS)
//   slave  : sequencer side (drives cell inputs and status)
interface aoi21_toggle_sequencer_if #(
  parameter int unsigned HOLD_W = 8,
  parameter int unsigned ITER_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              START;
  logic [HOLD_W-1:0] HOLD_CYC;
  logic [ITER_W-1:0] ITERS;
  logic              QN_OBS;
  logic              IN1;
  logic              IN2;
  logic              IN3;
  logic [2:0]        VEC_IDX;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [CNT_W-1:0]  TOGGLE_CNT;

  modport master (
    output START, HOLD_CYC, ITERS, QN_OBS,
    input  IN1, IN2, IN3, VEC_IDX, BUSY, DONE, ERR, TOGGLE_CNT
  );

  modport slave (
    input  START, HOLD_CYC, ITERS, QN_OBS,
    output IN1, IN2, IN3, VEC_IDX, BUSY, DONE, ERR, TOGGLE_CNT
  );
endinterface

// File: rtl/aoi21_toggle_counter.sv
// Observes the cell output: counts QN transitions (saturating) and keeps a
// sticky mismatch flag against the expected QN.
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : start of a run; zero count/flag, preset last QN to 1
//   en_i         : sample this cycle
//   qn_obs_i     : observed cell output
//   qn_exp_i     : ideal output for the vector currently driven
//   toggle_cnt_o : transitions seen since the last clear
//   err_o        : any mismatch seen since the last clear
module aoi21_toggle_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             qn_obs_i,
  input  logic             qn_exp_i,
  output logic [CNT_W-1:0] toggle_cnt_o,
  output logic             err_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             qn_q;
  logic             err_q;

  // The run starts from 000, whose ideal QN is 1, so that is the preset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      qn_q  <= 1'b1;
      err_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      qn_q  <= 1'b1;
      err_q <= 1'b0;
    end else if (en_i) begin
      if ((qn_obs_i != qn_q) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      qn_q <= qn_obs_i;
      if (qn_obs_i != qn_exp_i) begin
        err_q <= 1'b1;
      end
    end
  end

  assign toggle_cnt_o = cnt_q;
  assign err_o        = err_q;

endmodule

// File: rtl/aoi21_toggle_sequencer.sv
// Drives an AOI21 characterization bank through the 3-bit Gray sequence,
// holding each vector HOLD_CYC+1 cycles for ITERS passes, and checks/counts
// the cell output while busy.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of aoi21_toggle_sequencer_if (START/config in,
//              QN_OBS in, IN1..IN3, VEC_IDX, BUSY, DONE, ERR, TOGGLE_CNT out)
module aoi21_toggle_sequencer
  import aoi21_seq_pkg::*;
#(
  parameter int unsigned HOLD_W = 8,
  parameter int unsigned ITER_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  aoi21_toggle_sequencer_if.slave bus
);

  state_e            state_q;
  logic [HOLD_W-1:0] hold_cyc_q;
  logic [ITER_W-1:0] iters_q;
  logic [HOLD_W-1:0] hold_q;
  logic [ITER_W-1:0] pass_q;
  logic [2:0]        vec_idx_q;
  logic [2:0]        in_q;
  logic              busy_q;
  logic              done_q;

  logic [2:0] next_idx;
  logic       accept;

  assign next_idx = vec_idx_q + 3'd1;
  assign accept   = (state_q == IDLE) && bus.START;

  // Sequencer FSM with hold and pass counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      hold_cyc_q <= '0;
      iters_q    <= '0;
      hold_q     <= '0;
      pass_q     <= '0;
      vec_idx_q  <= '0;
      in_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.START) begin
            hold_cyc_q <= bus.HOLD_CYC;
            iters_q    <= bus.ITERS;
            hold_q     <= '0;
            pass_q     <= '0;
            vec_idx_q  <= '0;
            in_q       <= GRAY_VEC[0];
            if (bus.ITERS != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE_S;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hold_q == hold_cyc_q) begin
            hold_q <= '0;
            if (vec_idx_q == 3'd7) begin
              // Wrap to 000 either for the next pass or for the FINISH cycle.
              vec_idx_q <= '0;
              in_q      <= GRAY_VEC[0];
              if (pass_q == iters_q - ITER_W'(1)) begin
                state_q <= FINISH;
              end else begin
                pass_q <= pass_q + ITER_W'(1);
              end
            end else begin
              vec_idx_q <= next_idx;
              in_q      <= GRAY_VEC[next_idx];
            end
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        FINISH: begin
          state_q <= DONE_S;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE_S: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  aoi21_toggle_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk          (CLK),
    .rst          (RST),
    .clr_i        (accept),
    .en_i         (busy_q),
    .qn_obs_i     (bus.QN_OBS),
    .qn_exp_i     (IDEAL_QN[vec_idx_q]),
    .toggle_cnt_o (bus.TOGGLE_CNT),
    .err_o        (bus.ERR)
  );

  assign bus.IN1     = in_q[0];
  assign bus.IN2     = in_q[1];
  assign bus.IN3     = in_q[2];
  assign bus.VEC_IDX = vec_idx_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;

endmodule

// File: tb/tb_aoi21_toggle_sequencer.sv
// Testbench for aoi21_toggle_sequencer: two instances (16-bit and 2-bit
// toggle counter), cell bank modelled as an ideal AOI21 or a stuck-at-0
// output, expectations from a behavioural model of the sequence.
module tb_aoi21_toggle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel = 1'b0;   // 0: 16-bit counter DUT, 1: 2-bit counter DUT
  logic       tie0 = 1'b0;  // 1: cell output stuck at 0
  logic [7:0] hold_v = 8'd0;
  logic [7:0] iters_v = 8'd0;

  int vectors = 0;
  int miscompares = 0;

  aoi21_toggle_sequencer_if #(.HOLD_W(8), .ITER_W(8), .CNT_W(16)) bus16 ();
  aoi21_toggle_sequencer_if #(.HOLD_W(8), .ITER_W(8), .CNT_W(2))  bus2 ();

  aoi21_toggle_sequencer #(.HOLD_W(8), .ITER_W(8), .CNT_W(16)) dut16 (
    .CLK (clk), .RST (rst), .bus (bus16.slave)
  );
  aoi21_toggle_sequencer #(.HOLD_W(8), .ITER_W(8), .CNT_W(2)) dut2 (
    .CLK (clk), .RST (rst), .bus (bus2.slave)
  );

  always #5 clk = ~clk;

  assign bus16.START    = start & ~sel;
  assign bus2.START     = start & sel;
  assign bus16.HOLD_CYC = hold_v;
  assign bus2.HOLD_CYC  = hold_v;
  assign bus16.ITERS    = iters_v;
  assign bus2.ITERS     = iters_v;
  assign bus16.QN_OBS   = tie0 ? 1'b0 : ~(bus16.IN3 | (bus16.IN1 & bus16.IN2));
  assign bus2.QN_OBS    = tie0 ? 1'b0 : ~(bus2.IN3 | (bus2.IN1 & bus2.IN2));

  // Outputs of the selected instance.
  logic [2:0]  o_in;
  logic [2:0]  o_idx;
  logic        o_busy, o_done, o_err;
  logic [15:0] o_cnt;
  assign o_in   = sel ? {bus2.IN3, bus2.IN2, bus2.IN1} : {bus16.IN3, bus16.IN2, bus16.IN1};
  assign o_idx  = sel ? bus2.VEC_IDX : bus16.VEC_IDX;
  assign o_busy = sel ? bus2.BUSY : bus16.BUSY;
  assign o_done = sel ? bus2.DONE : bus16.DONE;
  assign o_err  = sel ? bus2.ERR : bus16.ERR;
  assign o_cnt  = sel ? 16'(bus2.TOGGLE_CNT) : bus16.TOGGLE_CNT;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic aoi(input logic [2:0] v);  // v = {IN3,IN2,IN1}
    return ~(v[2] | (v[0] & v[1]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int exp_cnt, input logic exp_err);
    check({tag, ".busy"}, 32'(o_busy), 32'd0);
    check({tag, ".done"}, 32'(o_done), 32'd0);
    check({tag, ".in"},   32'(o_in),   32'd0);
    check({tag, ".idx"},  32'(o_idx),  32'd0);
    check({tag, ".cnt"},  32'(o_cnt),  32'(exp_cnt));
    check({tag, ".err"},  32'(o_err),  32'(exp_err));
  endtask

  // One run: START, then every cycle compared against the model.
  // abort_k >= 0 applies RST during model cycle abort_k.
  task automatic do_run(input string tag, input bit s, input int h, input int it,
                        input bit tie, input bit poke, input int abort_k);
    int          n;
    int          prev_qn;
    int          cnt;
    int          maxc;
    bit          err;
    int          idx;
    logic [2:0]  v;
    logic        exp_qn;
    logic        qn;
    n       = 8 * (h + 1) * it;
    prev_qn = 1;
    cnt     = 0;
    err     = 1'b0;
    maxc    = s ? 3 : 65535;
    sel     = s;
    tie0    = tie;
    hold_v  = 8'(h);
    iters_v = 8'(it);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    hold_v  = 8'($urandom);  // late changes must not matter
    iters_v = 8'($urandom);
    if (it == 0) begin
      check({tag, ".z_done"}, 32'(o_done), 32'd1);
      check({tag, ".z_busy"}, 32'(o_busy), 32'd0);
      check({tag, ".z_in"},   32'(o_in),   32'd0);
      check({tag, ".z_cnt"},  32'(o_cnt),  32'd0);
      tick();
      check_idle({tag, ".z_after"}, 0, 1'b0);
      return;
    end
    for (int k = 0; k <= n; k++) begin
      idx    = (k < n) ? ((k / (h + 1)) % 8) : 0;
      v      = 3'(idx ^ (idx >> 1));
      exp_qn = aoi(v);
      qn     = tie ? 1'b0 : exp_qn;
      check($sformatf("%s.busy@%0d", tag, k), 32'(o_busy), 32'd1);
      check($sformatf("%s.done@%0d", tag, k), 32'(o_done), 32'd0);
      check($sformatf("%s.idx@%0d", tag, k),  32'(o_idx),  32'(idx));
      check($sformatf("%s.in@%0d", tag, k),   32'(o_in),   32'(v));
      check($sformatf("%s.cnt@%0d", tag, k),  32'(o_cnt),  32'(cnt));
      check($sformatf("%s.err@%0d", tag, k),  32'(o_err),  32'(err));
      if (int'(qn) != prev_qn) begin
        if (cnt < maxc) cnt++;
        prev_qn = int'(qn);
      end
      if (qn != exp_qn) err = 1'b1;
      if (k == abort_k) begin
        rst = 1'b1;
        tick();
        check_idle({tag, ".rst"}, 0, 1'b0);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
          tick();
          check_idle($sformatf("%s.post_rst%0d", tag, j), 0, 1'b0);
        end
        return;
      end
      start = poke && (k == 2);
      tick();
    end
    start = 1'b0;
    check({tag, ".done"},     32'(o_done), 32'd1);
    check({tag, ".done_bsy"}, 32'(o_busy), 32'd0);
    check({tag, ".done_in"},  32'(o_in),   32'd0);
    check({tag, ".fin_cnt"},  32'(o_cnt),  32'(cnt));
    check({tag, ".fin_err"},  32'(o_err),  32'(err));
    tick();
    check_idle({tag, ".after"}, cnt, err);
    tick();
    check_idle({tag, ".after2"}, cnt, err);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check_idle("reset16", 0, 1'b0);
    sel = 1'b1;
    check_idle("reset2", 0, 1'b0);
    sel = 1'b0;
    rst = 1'b0;
    tick();

    do_run("h0i1",  1'b0, 0, 1, 1'b0, 1'b0, -1);
    do_run("h3i2",  1'b0, 3, 2, 1'b0, 1'b0, -1);
    do_run("tie0",  1'b0, 0, 1, 1'b1, 1'b0, -1);
    do_run("iter0", 1'b0, 5, 0, 1'b0, 1'b0, -1);
    do_run("abort", 1'b0, 1, 1, 1'b0, 1'b0, 10);  // VEC_IDX=5 during cycle 10
    do_run("clean", 1'b0, 1, 1, 1'b0, 1'b0, -1);
    do_run("sat2",  1'b1, 0, 2, 1'b0, 1'b1, -1);

    for (int r = 0; r < 6; r++) begin
      do_run($sformatf("rnd%0d", r), 1'(r % 2), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aoi21_toggle_sequencer.md
Name: aoi21_toggle_sequencer

Overview:
Sequencer that drives the three inputs of a characterization bank of AOI21 cells through a fixed 3-bit Gray-code vector sequence for power/toggle measurement. It holds each vector for a programmable number of cycles and repeats the sequence a programmable number of passes. It also samples the cell output, counts output transitions and flags any mismatch against the ideal AOI21 function, QN = ~(IN3 | (IN1 & IN2)). It sits between the test controller (START/DONE handshake) and the cell-under-test bank.

Parameters:
HOLD_W, 8, width of HOLD_CYC; each vector is held HOLD_CYC+1 cycles
ITER_W, 8, width of ITERS (pass count)
CNT_W, 16, width of TOGGLE_CNT; the counter saturates at all-ones

Ports:
CLK  input  1  single clock, rising edge
RST  input  1  synchronous, active-high reset
START  input  1  one-cycle request; sampled only in IDLE
HOLD_CYC  input  HOLD_W  hold length, captured on START acceptance
ITERS  input  ITER_W  pass count, captured on START acceptance
QN_OBS  input  1  observed cell output (combinational from IN1..IN3)
IN1  output  1  cell input A1, registered
IN2  output  1  cell input A2, registered
IN3  output  1  cell input B, registered
VEC_IDX  output  3  current Gray index 0..7
BUSY  output  1  high while the sequence runs
DONE  output  1  one-cycle completion pulse
ERR  output  1  sticky mismatch flag, cleared on START acceptance
TOGGLE_CNT  output  CNT_W  QN transitions counted in the last run, held until next START

Behaviour:
- Reset: state IDLE. IN1..IN3=0, VEC_IDX=0, BUSY=0, DONE=0, ERR=0, TOGGLE_CNT=0, internal counters=0. RST mid-run aborts immediately to this state, with no DONE.
- Vector order by VEC_IDX 0..7, as {IN3,IN2,IN1}: 000,001,011,010,110,111,101,100. Ideal QN: 1,1,0,1,0,0,0,0.
- States: IDLE, RUN, FINISH, DONE_S.
- IDLE:
  - START=1 and ITERS!=0: capture HOLD_CYC/ITERS, clear TOGGLE_CNT and ERR, preset qn_q=1, VEC_IDX=0, drive 000, then go to RUN. BUSY=1 from the next cycle.
  - START=1 and ITERS==0: go directly to DONE_S. TOGGLE_CNT=0, no vectors driven.
- RUN:
  - Hold counter counts 0..HOLD_CYC.
  - At HOLD_CYC, VEC_IDX increments. After index 7, the pass counter increments and VEC_IDX wraps to 0.
  - After index 7 of the final pass, drive 000 and go to FINISH.
- FINISH: one cycle with 000 driven, so the wrap-back transition is sampled. Then go to DONE_S.
- DONE_S: DONE=1 and BUSY=0 for exactly one cycle, then IDLE.
- BUSY cycle count = 8*(HOLD_CYC+1)*ITERS + 1 (RUN plus FINISH).
- Sampling, every BUSY cycle:
  - If QN_OBS != qn_q, TOGGLE_CNT increments (saturating), then qn_q <= QN_OBS.
  - If QN_OBS != the ideal QN of the currently driven vector, ERR <= 1.
  - The cell settles within one cycle, so there is no extra pipeline delay.
- Ideal cell gives TOGGLE_CNT = 4*ITERS (011, 010, 110 and wrap-to-000 edges per pass).
- START while BUSY or in DONE_S is ignored. HOLD_CYC/ITERS changes after acceptance have no effect.
- IN1..IN3 change only on clock edges, and no more than one input changes per edge (Gray property, including wrap).

Decomposition:
- Shared package aoi21_seq_pkg:
  - state enum (IDLE, RUN, FINISH, DONE_S)
  - 8-entry Gray vector constant table
  - 8-entry ideal-QN constant table
- One sub-module: aoi21_toggle_counter. It holds qn_q, the saturating TOGGLE_CNT and the sticky ERR, and takes clear/enable/expected inputs.
- The FSM and the hold/pass counters stay in the top module.

Test Plan:
- Ideal model, HOLD_CYC=0, ITERS=1: START -> 9 BUSY cycles, vectors in Gray order one per cycle, DONE 1 cycle after FINISH, TOGGLE_CNT=4, ERR=0.
- Ideal model, HOLD_CYC=3, ITERS=2: each vector held 4 cycles, BUSY=65 cycles, TOGGLE_CNT=8, single-bit input changes only.
- QN_OBS tied 0, HOLD_CYC=0, ITERS=1: ERR=1 from first BUSY cycle, TOGGLE_CNT=1.
- ITERS=0: DONE asserted the cycle after START, BUSY never high, TOGGLE_CNT=0, inputs stay 000.
- RST asserted at VEC_IDX=5 mid-run: next cycle all outputs at reset values, no DONE. A new START afterwards runs the full sequence cleanly.
- CNT_W=2 override, ITERS=2, ideal model: TOGGLE_CNT saturates at 3. START pulsed while BUSY is ignored, and the run still completes exactly once.
